// File: rtl/min_density_encoder_pkg.sv
// Shared types and helpers for the minimum-density encoder.
//   state_t        : encoder FSM states
//   popcount_lane  : counts the ones in a zero-extended lane slice
package min5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIX   = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Widest lane the popcount helper accepts; narrower lanes are zero-extended.
    localparam int MAX_LANE = 32;

    function automatic logic [5:0] popcount_lane(input logic [MAX_LANE-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MAX_LANE; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/min_density_encoder_lane_popcount.sv
// Combinational popcount of one LANE-bit slice.
//   lane   in   LANE              slice to count
//   count  out  $clog2(LANE+1)    number of ones in the slice
module lane_popcount
    import min5_pkg::*;
#(
    parameter int LANE = 4
) (
    input  logic [LANE-1:0]           lane,
    output logic [$clog2(LANE+1)-1:0] count
);

    localparam int CNT_W = $clog2(LANE+1);

    logic [MAX_LANE-1:0] lane_ext;

    assign lane_ext = MAX_LANE'(lane);
    assign count    = CNT_W'(popcount_lane(lane_ext));

endmodule

// File: rtl/min_density_encoder.sv
// Minimum-density encoder: accepts arbitrary WIDTH-bit words and emits words
// holding at least MIN_CNT ones and MIN_CNT zeroes, forcing the fewest bits
// scanned LSB first. Ones are counted LANE bits per cycle, then bits are fixed
// one index per cycle.
//   clk        in   1      clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      upstream word valid
//   in_data    in   WIDTH  upstream word
//   in_ready   out  1      encoder idle and able to accept
//   out_valid  out  1      encoded word valid, held until accepted
//   out_data   out  WIDTH  encoded word
//   out_mod    out  1      at least one bit was forced
//   out_ready  in   1      downstream accepts
//   fix_count  out  16     modified-word counter (only with MIN5_STATS_EN)
// Build option MIN5_STATS_EN adds the saturating fix_count statistics counter.
//
// state | meaning
// IDLE  | in_ready high, waiting for an upstream word
// COUNT | accumulating ones, one LANE slice per cycle, LSB slice first
// FIX   | walking bit indices from 0, forcing bits until the deficit is gone
// OUT   | encoded word presented, waiting for out_ready
module min_density_encoder
    import min5_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MIN_CNT = 5,
    parameter int LANE    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mod,
    input  logic             out_ready
`ifdef MIN5_STATS_EN
    ,
    output logic [15:0]      fix_count
`endif
);

    localparam int NLANE = WIDTH / LANE;
    localparam int IW    = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int XW    = $clog2(WIDTH);
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int LW    = $clog2(LANE + 1);

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    ones_q;
    logic [CW-1:0]    deficit_q;
    logic             short_ones_q;
    logic [IW-1:0]    lane_idx;
    logic [XW-1:0]    fix_idx;

    logic [XW-1:0]    slice_lsb;
    logic [LW-1:0]    lane_cnt;
    logic [CW-1:0]    ones_sum;
    logic [CW-1:0]    zeros_sum;
    logic [CW-1:0]    deficit_new;
    logic             short_ones_new;
    logic             bit_forceable;
    logic [WIDTH-1:0] fixed_word;

    assign slice_lsb = XW'(lane_idx) * XW'(LANE);

    lane_popcount #(.LANE(LANE)) u_lane_popcount (
        .lane  (data_q[slice_lsb +: LANE]),
        .count (lane_cnt)
    );

    // Final tally as of the last COUNT cycle; only one deficit can be non-zero.
    always_comb begin
        ones_sum       = ones_q + CW'(lane_cnt);
        zeros_sum      = CW'(WIDTH) - ones_sum;
        deficit_new    = '0;
        short_ones_new = 1'b0;
        if (ones_sum < CW'(MIN_CNT)) begin
            deficit_new    = CW'(MIN_CNT) - ones_sum;
            short_ones_new = 1'b1;
        end else if (zeros_sum < CW'(MIN_CNT)) begin
            deficit_new = CW'(MIN_CNT) - zeros_sum;
        end
    end

    // A bit is forced only if it currently holds the over-represented value.
    always_comb begin
        bit_forceable       = short_ones_q ? ~data_q[fix_idx] : data_q[fix_idx];
        fixed_word          = data_q;
        fixed_word[fix_idx] = short_ones_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            data_q       <= '0;
            ones_q       <= '0;
            deficit_q    <= '0;
            short_ones_q <= 1'b0;
            lane_idx     <= '0;
            fix_idx      <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_mod      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        data_q   <= in_data;
                        ones_q   <= '0;
                        lane_idx <= '0;
                        in_ready <= 1'b0;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    ones_q   <= ones_sum;
                    lane_idx <= lane_idx + IW'(1);
                    if (lane_idx == IW'(NLANE - 1)) begin
                        deficit_q    <= deficit_new;
                        short_ones_q <= short_ones_new;
                        fix_idx      <= '0;
                        if (deficit_new == '0) begin
                            out_valid <= 1'b1;
                            out_data  <= data_q;
                            out_mod   <= 1'b0;
                            state     <= OUT;
                        end else begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    fix_idx <= fix_idx + XW'(1);
                    if (bit_forceable) begin
                        data_q    <= fixed_word;
                        deficit_q <= deficit_q - CW'(1);
                        if (deficit_q == CW'(1)) begin
                            out_valid <= 1'b1;
                            out_data  <= fixed_word;
                            out_mod   <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MIN5_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fix_count <= '0;
        end else if (state == OUT && out_valid && out_ready && out_mod
                     && fix_count != 16'hFFFF) begin
            fix_count <= fix_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_min_density_encoder.sv
module tb_min_density_encoder;

    localparam int WIDTH   = 32;
    localparam int MIN_CNT = 5;
    localparam int LANE    = 4;
    localparam int NLANE   = WIDTH / LANE;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_mod;
    logic             out_ready;
`ifdef MIN5_STATS_EN
    logic [15:0]      fix_count;
`endif

    min_density_encoder #(.WIDTH(WIDTH), .MIN_CNT(MIN_CNT), .LANE(LANE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_mod   (out_mod),
        .out_ready (out_ready)
`ifdef MIN5_STATS_EN
        ,
        .fix_count (fix_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: count ones, then force the lowest over-represented bits.
    function automatic void model(input logic [WIDTH-1:0] w, output logic [WIDTH-1:0] o,
                                  output logic m, output int lat);
        int ones;
        int need;
        int high;
        logic want;
        ones = $countones(w);
        o    = w;
        high = -1;
        need = 0;
        want = 1'b0;
        if (ones < MIN_CNT) begin
            need = MIN_CNT - ones;
            want = 1'b1;
        end else if (WIDTH - ones < MIN_CNT) begin
            need = MIN_CNT - (WIDTH - ones);
            want = 1'b0;
        end
        for (int i = 0; i < WIDTH && need > 0; i++) begin
            if (o[i] != want) begin
                o[i] = want;
                need--;
                high = i;
            end
        end
        m   = (high >= 0);
        lat = NLANE + ((high >= 0) ? high + 1 : 0);
    endfunction

    // Cycle monitor: checks outputs against the model on every cycle.
    int          cyc = 0;
    int          since_rst = 0;
    bit          busy = 0;
    int          rise = 0;
    logic [31:0] exp_data;
    logic        exp_mod;
    int          exp_fix = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) since_rst = 0;
        else if (since_rst < 1000) since_rst++;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int lat;
        if (!reset_n) begin
            busy    = 0;
            exp_fix = 0;
        end else begin
`ifdef MIN5_STATS_EN
            chk("mon_fix_count", 32'(fix_count), 32'(exp_fix));
`endif
            if (busy) begin
                chk("mon_in_ready_busy", 32'(in_ready), 32'd0);
                if (cyc < rise) begin
                    chk("mon_out_valid_early", 32'(out_valid), 32'd0);
                end else begin
                    chk("mon_out_valid", 32'(out_valid), 32'd1);
                    chk("mon_out_data", out_data, exp_data);
                    chk("mon_out_mod", 32'(out_mod), 32'(exp_mod));
                    if (out_valid && out_ready) begin
                        busy = 0;
                        if (exp_mod && exp_fix < 16'hFFFF) exp_fix++;
                    end
                end
            end else begin
                chk("mon_out_valid_idle", 32'(out_valid), 32'd0);
                if (since_rst >= 1) chk("mon_in_ready_idle", 32'(in_ready), 32'd1);
                if (in_valid && in_ready) begin
                    model(in_data, exp_data, exp_mod, lat);
                    busy = 1;
                    rise = cyc + 1 + lat;
                end
            end
        end
    end

    // Directed driver helpers; all called at posedge+1.
    task automatic wait_ready();
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wait_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_result(input logic [31:0] exp_w, input logic exp_m, input int exp_lat,
                               input bit do_xfer);
        int edges;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!out_valid && edges < 64);
        chk("latency", 32'(edges), 32'(exp_lat));
        chk("out_data", out_data, exp_w);
        chk("out_mod", 32'(out_mod), 32'(exp_m));
        if (do_xfer && out_ready) begin
            @(posedge clk); #1;
            chk("xfer_drop_valid", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] exp_w, input logic exp_m,
                        input int exp_lat);
        wait_ready();
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(exp_w, exp_m, exp_lat, 1'b1);
    endtask

    logic [31:0] vec_in  [12];
    logic [31:0] vec_out [12];
    logic        vec_mod [12];
    int          vec_lat [12];

    initial begin
        logic [31:0] mo;
        logic        mm;
        int          ml;
        logic [31:0] w;

        vec_in[0]  = 32'h0000_0000; vec_out[0]  = 32'h0000_001F; vec_mod[0]  = 1; vec_lat[0]  = 13;
        vec_in[1]  = 32'hFFFF_FFFF; vec_out[1]  = 32'hFFFF_FFE0; vec_mod[1]  = 1; vec_lat[1]  = 13;
        vec_in[2]  = 32'h0000_0003; vec_out[2]  = 32'h0000_001F; vec_mod[2]  = 1; vec_lat[2]  = 13;
        vec_in[3]  = 32'h0000_FFFF; vec_out[3]  = 32'h0000_FFFF; vec_mod[3]  = 0; vec_lat[3]  = 8;
        vec_in[4]  = 32'h0000_0010; vec_out[4]  = 32'h0000_001F; vec_mod[4]  = 1; vec_lat[4]  = 12;
        vec_in[5]  = 32'h8000_0000; vec_out[5]  = 32'h8000_000F; vec_mod[5]  = 1; vec_lat[5]  = 12;
        vec_in[6]  = 32'h7FFF_FFFF; vec_out[6]  = 32'h7FFF_FFF0; vec_mod[6]  = 1; vec_lat[6]  = 12;
        vec_in[7]  = 32'hFFFF_FFF5; vec_out[7]  = 32'hFFFF_FFE0; vec_mod[7]  = 1; vec_lat[7]  = 13;
        vec_in[8]  = 32'h0000_001F; vec_out[8]  = 32'h0000_001F; vec_mod[8]  = 0; vec_lat[8]  = 8;
        vec_in[9]  = 32'hFFFF_FFE0; vec_out[9]  = 32'hFFFF_FFE0; vec_mod[9]  = 0; vec_lat[9]  = 8;
        vec_in[10] = 32'h0000_000F; vec_out[10] = 32'h0000_001F; vec_mod[10] = 1; vec_lat[10] = 13;
        vec_in[11] = 32'h0000_0155; vec_out[11] = 32'h0000_0155; vec_mod[11] = 0; vec_lat[11] = 8;

        // Pin the model against the hand-computed table.
        for (int i = 0; i < 12; i++) begin
            model(vec_in[i], mo, mm, ml);
            chk("model_data", mo, vec_out[i]);
            chk("model_lat", 32'(ml), 32'(vec_lat[i]));
        end

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_mod", 32'(out_mod), 32'd0);
        reset_n = 1'b1;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) send(vec_in[i], vec_out[i], vec_mod[i], vec_lat[i]);

        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            if (i % 2 == 0) w = w & 32'h0001_0204;
            model(w, mo, mm, ml);
            send(w, mo, mm, ml);
        end

        // Backpressure: hold out_ready low 10 cycles while a new word waits.
        wait_ready();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0000;
        @(posedge clk); #1;
        in_data = 32'h0000_FFFF;
        wait_result(32'h0000_001F, 1'b1, 13, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, 32'h0000_001F);
            chk("hold_mod", 32'(out_mod), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_xfer_valid", 32'(out_valid), 32'd0);
        chk("post_xfer_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("next_accept_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_result(32'h0000_FFFF, 1'b0, 8, 1'b1);

        // Reset in the middle of COUNT.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 32'h0000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_count_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_count_rst_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_count_rel_ready", 32'(in_ready), 32'd1);

        // Reset while a word is held in OUT.
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        in_data  = 32'h8000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(32'h8000_000F, 1'b1, 12, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_out_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_out_rst_data", out_data, 32'd0);
        chk("mid_out_rst_mod", 32'(out_mod), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_out_rel_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 4; i++) send(vec_in[i], vec_out[i], vec_mod[i], vec_lat[i]);
`ifdef MIN5_STATS_EN
        chk("fix_count_three", 32'(fix_count), 32'd3);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
